// File: rtl/trn_stat.sv
// trn_stat: TRN-side link/packet/error statistics packed into one status word for sys_clk.
// Latency: packet counters update 1 cycle after the beat; stat_trn 1 cycle after the counters.
// Backpressure: none; passively observes the rx/tx handshakes and never stalls the TRN interface.
//
// Ports:
//   trn_clk, trn_reset_n            TRN clock, asynchronous active-low reset
//   trn_lnk_up_n                    link status, low = link up
//   trn_rsof_n, trn_reof_n          rx start/end of frame (active low)
//   trn_rsrc_rdy_n, trn_rdst_rdy_n  rx handshake (active low)
//   trn_tsof_n, trn_teof_n          tx start/end of frame (active low)
//   trn_tsrc_rdy_n, trn_tdst_rdy_n  tx handshake (active low)
//   trn_fc_sel, trn_fc_ph           flow-control selector and posted-header credits
//   stat_trn                        {1'b1, fc_sel[2:0], err_cnt[3:0], fc_ph[7:0], tx_cnt[7:0], rx_cnt[7:0]}
//
// Build option TRN_STAT_HOLD_EN: stat_trn refreshes only once every 16 ACTIVE
// cycles, so the multi-bit word stays stable long enough to be sampled in sys_clk.

module trn_stat (
  input  logic        trn_clk,
  input  logic        trn_reset_n,
  input  logic        trn_lnk_up_n,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rdst_rdy_n,
  input  logic        trn_tsof_n,
  input  logic        trn_teof_n,
  input  logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [2:0]  trn_fc_sel,
  input  logic [7:0]  trn_fc_ph,
  output logic [31:0] stat_trn
);

  // --------------------------------------------------------------------------
  // Link FSM
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    LINK_DOWN = 1'b0,
    ACTIVE    = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   run;  // ACTIVE and link still up: the only cycles in which beats count

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state <= LINK_DOWN;
    end else begin
      state <= state_nxt;
    end
  end

  // The cycle that brings the link up is still a LINK_DOWN cycle, so its
  // beats are ignored; the cycle that drops the link clears everything.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    case (state)
      LINK_DOWN: begin
        if (!trn_lnk_up_n) begin
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (trn_lnk_up_n) begin
          state_nxt = LINK_DOWN;
        end else begin
          run = 1'b1;
        end
      end
      default: begin
        state_nxt = LINK_DOWN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Beat decode
  // --------------------------------------------------------------------------
  logic rx_beat;
  logic tx_beat;

  assign rx_beat = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
  assign tx_beat = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;

  // --------------------------------------------------------------------------
  // Per-direction packet tracker
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic in_pkt;   // next value of the in-packet flag
    logic cnt_inc;  // a packet completes on this beat
    logic err;      // framing error on this beat
  } trk_t;

  // sof while a packet is open aborts it (error, not counted) and the new
  // packet takes its place; sof+eof on one beat is always a complete packet.
  // eof with nothing open and no sof is an orphan and only counts as an error.
  function automatic trk_t pkt_trk(input logic beat, input logic sof,
                                   input logic eof, input logic in_pkt);
    trk_t t;
    t.in_pkt  = in_pkt;
    t.cnt_inc = 1'b0;
    t.err     = 1'b0;
    if (beat) begin
      t.cnt_inc = eof && (sof || in_pkt);
      t.err     = (sof && in_pkt) || (eof && !sof && !in_pkt);
      if (sof) begin
        t.in_pkt = !eof;
      end else if (eof) begin
        t.in_pkt = 1'b0;
      end
    end
    return t;
  endfunction

  logic rx_in_pkt;
  logic tx_in_pkt;
  trk_t rx_trk;
  trk_t tx_trk;

  assign rx_trk = pkt_trk(rx_beat, !trn_rsof_n, !trn_reof_n, rx_in_pkt);
  assign tx_trk = pkt_trk(tx_beat, !trn_tsof_n, !trn_teof_n, tx_in_pkt);

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  logic [7:0] rx_cnt;
  logic [7:0] tx_cnt;
  logic [3:0] err_cnt;
  logic [4:0] err_sum;
  logic [3:0] err_cnt_nxt;

  // Up to two errors per cycle (one per direction); saturate at 15.
  assign err_sum     = {1'b0, err_cnt} + {4'd0, rx_trk.err} + {4'd0, tx_trk.err};
  assign err_cnt_nxt = err_sum[4] ? 4'hF : err_sum[3:0];

  // Outside run everything returns to zero, which also drops any open
  // packet on a link loss without counting it or flagging an error.
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      rx_in_pkt <= 1'b0;
      tx_in_pkt <= 1'b0;
      rx_cnt    <= 8'd0;
      tx_cnt    <= 8'd0;
      err_cnt   <= 4'd0;
    end else if (!run) begin
      rx_in_pkt <= 1'b0;
      tx_in_pkt <= 1'b0;
      rx_cnt    <= 8'd0;
      tx_cnt    <= 8'd0;
      err_cnt   <= 4'd0;
    end else begin
      rx_in_pkt <= rx_trk.in_pkt;
      tx_in_pkt <= tx_trk.in_pkt;
      rx_cnt    <= rx_cnt + {7'd0, rx_trk.cnt_inc};
      tx_cnt    <= tx_cnt + {7'd0, tx_trk.cnt_inc};
      err_cnt   <= err_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Status word
  // --------------------------------------------------------------------------
  logic [31:0] stat_nxt;
  logic        stat_upd;

  // Built from the counter registers as they stand this cycle, so the word
  // trails the counters by one cycle.
  assign stat_nxt = {1'b1, trn_fc_sel, err_cnt, trn_fc_ph, tx_cnt, rx_cnt};

`ifdef TRN_STAT_HOLD_EN
  logic [3:0] hold_cnt;

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      hold_cnt <= 4'd0;
    end else if (!run) begin
      hold_cnt <= 4'd0;
    end else begin
      hold_cnt <= hold_cnt + 4'd1;
    end
  end

  // First refresh lands on the 16th ACTIVE cycle, then every 16 cycles.
  assign stat_upd = run && (hold_cnt == 4'hF);
`else
  assign stat_upd = run;
`endif

  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      stat_trn <= 32'd0;
    end else if (!run) begin
      stat_trn <= 32'd0;
    end else if (stat_upd) begin
      stat_trn <= stat_nxt;
    end
  end

endmodule

// File: tb/tb_trn_stat.sv
// tb_trn_stat: directed bench for trn_stat with hand-computed status words.
// Latency: inputs change 1 time unit after posedge; stat_trn is sampled there too.
// Backpressure: not applicable; the DUT has no ready outputs.

module tb_trn_stat;

  logic        trn_clk;
  logic        trn_reset_n;
  logic        trn_lnk_up_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rdst_rdy_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic [2:0]  trn_fc_sel;
  logic [7:0]  trn_fc_ph;
  logic [31:0] stat_trn;

  int checks = 0;
  int errors = 0;

  trn_stat dut (
    .trn_clk        (trn_clk),
    .trn_reset_n    (trn_reset_n),
    .trn_lnk_up_n   (trn_lnk_up_n),
    .trn_rsof_n     (trn_rsof_n),
    .trn_reof_n     (trn_reof_n),
    .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
    .trn_rdst_rdy_n (trn_rdst_rdy_n),
    .trn_tsof_n     (trn_tsof_n),
    .trn_teof_n     (trn_teof_n),
    .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
    .trn_tdst_rdy_n (trn_tdst_rdy_n),
    .trn_fc_sel     (trn_fc_sel),
    .trn_fc_ph      (trn_fc_ph),
    .stat_trn       (stat_trn)
  );

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  task automatic step();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: stat_trn=%08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rdst_rdy_n = 1'b1;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    trn_tdst_rdy_n = 1'b1;
  endtask

  // rx/tx each {beat, sof, eof}, active high; one clock, then bus idle.
  task automatic beat(input logic [2:0] rx, input logic [2:0] tx);
    trn_rsrc_rdy_n = !rx[2];
    trn_rdst_rdy_n = !rx[2];
    trn_rsof_n     = !rx[1];
    trn_reof_n     = !rx[0];
    trn_tsrc_rdy_n = !tx[2];
    trn_tdst_rdy_n = !tx[2];
    trn_tsof_n     = !tx[1];
    trn_teof_n     = !tx[0];
    step();
    idle_bus();
  endtask

  task automatic rx_pkt4();
    beat(3'b110, 3'b000);
    beat(3'b100, 3'b000);
    beat(3'b100, 3'b000);
    beat(3'b101, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_bus();
    trn_reset_n  = 1'b0;
    trn_lnk_up_n = 1'b1;
    trn_fc_sel   = 3'b101;
    trn_fc_ph    = 8'h3C;
    step();
    step();
    chk("reset", stat_trn, 32'h0000_0000);

`ifdef TRN_STAT_HOLD_EN
    trn_reset_n = 1'b1;
    step();
    trn_lnk_up_n = 1'b0;
    step();
    chk("hold_up", stat_trn, 32'h0000_0000);
    // Packets: sof on ACTIVE cycle 8i+1, eof on 8i+2; refreshes after cycles 16, 32, 48.
    for (int a = 1; a <= 48; a++) begin
      if (a <= 40 && (a % 8) == 1) beat(3'b110, 3'b000);
      else if (a <= 40 && (a % 8) == 2) beat(3'b101, 3'b000);
      else step();
      if (a < 16)      chk("hold", stat_trn, 32'h0000_0000);
      else if (a < 32) chk("hold", stat_trn, 32'hD03C_0002);
      else if (a < 48) chk("hold", stat_trn, 32'hD03C_0004);
      else             chk("hold", stat_trn, 32'hD03C_0005);
    end
`else
    trn_reset_n = 1'b1;
    step();
    chk("down_idle", stat_trn, 32'h0000_0000);

    // Link comes up with rx and tx single-beat packets in the same cycle: ignored.
    trn_lnk_up_n = 1'b0;
    beat(3'b111, 3'b111);
    chk("up_cycle", stat_trn, 32'h0000_0000);
    step();
    chk("link_up", stat_trn, 32'hD03C_0000);

    // Source ready without destination ready is not a beat.
    trn_rsof_n     = 1'b0;
    trn_reof_n     = 1'b0;
    trn_rsrc_rdy_n = 1'b0;
    trn_rdst_rdy_n = 1'b1;
    step();
    idle_bus();
    step();
    chk("no_hs", stat_trn, 32'hD03C_0000);

    repeat (3) rx_pkt4();
    chk("rx_lat", stat_trn, 32'hD03C_0002);
    step();
    chk("rx3", stat_trn, 32'hD03C_0003);

    // Abort: sof, sof, eof -> one packet, one error.
    beat(3'b110, 3'b000);
    beat(3'b110, 3'b000);
    beat(3'b101, 3'b000);
    step();
    chk("abort", stat_trn, 32'hD13C_0004);

    repeat (255) beat(3'b000, 3'b111);
    step();
    chk("tx255", stat_trn, 32'hD13C_FF04);
    beat(3'b000, 3'b111);
    step();
    chk("tx_wrap", stat_trn, 32'hD13C_0004);

    repeat (13) beat(3'b000, 3'b101);
    step();
    chk("err14", stat_trn, 32'hDE3C_0004);
    beat(3'b101, 3'b101);
    step();
    chk("err_dual", stat_trn, 32'hDF3C_0004);
    repeat (20) beat(3'b000, 3'b101);
    step();
    chk("err_sat", stat_trn, 32'hDF3C_0004);

    // Link drop in the middle of an rx packet.
    beat(3'b110, 3'b000);
    beat(3'b100, 3'b000);
    trn_lnk_up_n = 1'b1;
    step();
    chk("drop", stat_trn, 32'h0000_0000);
    beat(3'b111, 3'b111);
    step();
    chk("down", stat_trn, 32'h0000_0000);
    trn_lnk_up_n = 1'b0;
    step();
    step();
    chk("return", stat_trn, 32'hD03C_0000);
    beat(3'b110, 3'b000);
    beat(3'b101, 3'b000);
    step();
    chk("restart", stat_trn, 32'hD03C_0001);

    beat(3'b000, 3'b110);
    beat(3'b000, 3'b101);
    step();
    chk("tx_pkt", stat_trn, 32'hD03C_0101);

    trn_fc_sel = 3'b010;
    trn_fc_ph  = 8'hA5;
    step();
    chk("fc", stat_trn, 32'hA0A5_0101);

    beat(3'b101, 3'b000);
    step();
    chk("rx_orphan", stat_trn, 32'hA1A5_0101);

    // Asynchronous reset between clock edges, then release with link up.
    #2;
    trn_reset_n = 1'b0;
    #1;
    chk("async_rst", stat_trn, 32'h0000_0000);
    step();
    trn_reset_n = 1'b1;
    beat(3'b111, 3'b000);
    step();
    chk("rst_rel", stat_trn, 32'hA0A5_0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
